// File: rtl/minterm_sweep_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the minterm sweep sequencer.
// Default masks are the canonical truth tables of the minimized F1/F2 lab circuits.
package minterm_sweep_ctrl_pkg;

    localparam int          N_MINTERMS  = 16;
    localparam logic [15:0] F1_MASK_DEF = 16'h0F5F;
    localparam logic [15:0] F2_MASK_DEF = 16'hADA8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Number of functions flagged in a {F2,F1} miss vector (0..2).
    function automatic logic [1:0] miss_count(input logic [1:0] miss);
        return {1'b0, miss[0]} + {1'b0, miss[1]};
    endfunction

endpackage

// File: rtl/minterm_sweep_ctrl_settle_timer.sv
// Settle-delay down-counter: load a start value, count down while enabled,
// and flag expiry once the count reaches zero.
module sweep_settle_timer
    import minterm_sweep_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    output logic       expired
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == 4'd0);

endmodule

// File: rtl/minterm_sweep_ctrl.sv
// Sweeps all 16 {A,B,C,D} vectors into the F1/F2 circuits under test, samples
// both outputs after a settle delay and accumulates mismatch results.
module minterm_sweep_ctrl
    import minterm_sweep_ctrl_pkg::*;
#(
    parameter int          SETTLE  = 2,
    parameter logic [15:0] F1_MASK = F1_MASK_DEF,
    parameter logic [15:0] F2_MASK = F2_MASK_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic [3:0] vec_o,
    input  logic       f1_i,
    input  logic       f2_i,
    output logic       busy,
    output logic       done,
    output logic       result_valid,
    output logic       pass,
    output logic [5:0] err_cnt,
    output logic [3:0] fail_idx,
    output logic [1:0] fail_fn
);

    // The timer holds SETTLE-1 so that SETTLE state lasts exactly SETTLE cycles.
    localparam logic [3:0] SETTLE_LOAD = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
    localparam state_e     VEC_STATE   = (SETTLE > 0) ? ST_SETTLE : ST_SAMPLE;

    state_e     state_q,        state_d;
    logic [3:0] vec_q,          vec_d;
    logic [5:0] err_cnt_q,      err_cnt_d;
    logic [3:0] fail_idx_q,     fail_idx_d;
    logic [1:0] fail_fn_q,      fail_fn_d;
    logic       result_valid_q, result_valid_d;
    logic       pass_q,         pass_d;

    logic       timer_load;
    logic       timer_en;
    logic       timer_expired;
    logic [1:0] f_miss;

    sweep_settle_timer u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (SETTLE_LOAD),
        .en       (timer_en),
        .expired  (timer_expired)
    );

    assign f_miss = {f2_i != F2_MASK[vec_q], f1_i != F1_MASK[vec_q]};

    always_comb begin
        state_d        = state_q;
        vec_d          = vec_q;
        err_cnt_d      = err_cnt_q;
        fail_idx_d     = fail_idx_q;
        fail_fn_d      = fail_fn_q;
        result_valid_d = result_valid_q;
        pass_d         = pass_q;
        timer_load     = 1'b0;
        timer_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    vec_d          = 4'd0;
                    err_cnt_d      = 6'd0;
                    fail_idx_d     = 4'd0;
                    fail_fn_d      = 2'b00;
                    result_valid_d = 1'b0;
                    pass_d         = 1'b0;
                    timer_load     = 1'b1;
                    state_d        = VEC_STATE;
                end
            end
            ST_SETTLE: begin
                timer_en = 1'b1;
                if (timer_expired) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                // err_cnt still zero means this is the first miss of the sweep.
                if (f_miss != 2'b00) begin
                    err_cnt_d = err_cnt_q + 6'(miss_count(f_miss));
                    if (err_cnt_q == 6'd0) begin
                        fail_idx_d = vec_q;
                        fail_fn_d  = f_miss;
                    end
                end
                if (vec_q != 4'd15) begin
                    vec_d      = vec_q + 4'd1;
                    timer_load = 1'b1;
                    state_d    = VEC_STATE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                result_valid_d = 1'b1;
                pass_d         = (err_cnt_q == 6'd0);
                state_d        = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort freezes every result register and wins over any transition.
        if (abort) begin
            state_d        = ST_IDLE;
            vec_d          = vec_q;
            err_cnt_d      = err_cnt_q;
            fail_idx_d     = fail_idx_q;
            fail_fn_d      = fail_fn_q;
            result_valid_d = result_valid_q;
            pass_d         = pass_q;
            timer_load     = 1'b0;
            timer_en       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            vec_q          <= 4'd0;
            err_cnt_q      <= 6'd0;
            fail_idx_q     <= 4'd0;
            fail_fn_q      <= 2'b00;
            result_valid_q <= 1'b0;
            pass_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            vec_q          <= vec_d;
            err_cnt_q      <= err_cnt_d;
            fail_idx_q     <= fail_idx_d;
            fail_fn_q      <= fail_fn_d;
            result_valid_q <= result_valid_d;
            pass_q         <= pass_d;
        end
    end

    assign vec_o        = vec_q;
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);
    assign result_valid = result_valid_q;
    assign pass         = pass_q;
    assign err_cnt      = err_cnt_q;
    assign fail_idx     = fail_idx_q;
    assign fail_fn      = fail_fn_q;

endmodule

// File: tb/tb_minterm_sweep_ctrl.sv
// Self-checking bench for minterm_sweep_ctrl: models the F1/F2 lab circuits
// (golden or stuck), predicts sweep results into a queue and checks them at done.
module tb_minterm_sweep_ctrl;

    localparam logic [15:0] F1_REF = 16'h0F5F;
    localparam logic [15:0] F2_REF = 16'hADA8;

    typedef struct {
        int         err;
        logic [3:0] idx;
        logic [1:0] fn;
        logic       pass;
        int         edge_n;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic       abort;
    logic [1:0] mode;
    logic       start0;

    logic [3:0] vec, vec0;
    logic       f1, f2, f1_0, f2_0;
    logic       busy, done, result_valid, pass;
    logic       busy0, done0, result_valid0, pass0;
    logic [5:0] err_cnt, err_cnt0;
    logic [3:0] fail_idx, fail_idx0;
    logic [1:0] fail_fn, fail_fn0;

    // Circuit models: F1 = B' + A'D', F2 = BD + CD + AB'D'
    function automatic logic golden_f1(input logic [3:0] v);
        return !v[2] | (!v[3] & !v[0]);
    endfunction

    function automatic logic golden_f2(input logic [3:0] v);
        return (v[2] & v[0]) | (v[1] & v[0]) | (v[3] & !v[2] & !v[0]);
    endfunction

    function automatic logic circuit_f1(input logic [1:0] m, input logic [3:0] v);
        return (m == 2'd0) ? golden_f1(v) : 1'b0;
    endfunction

    function automatic logic circuit_f2(input logic [1:0] m, input logic [3:0] v);
        return (m == 2'd2) ? 1'b1 : golden_f2(v);
    endfunction

    function automatic exp_t model(input logic [1:0] m, input int settle);
        exp_t       e;
        logic [1:0] miss;
        logic [3:0] v;
        bit         found;
        e.err  = 0;
        e.idx  = 4'd0;
        e.fn   = 2'b00;
        found  = 0;
        for (int i = 0; i < 16; i++) begin
            v    = 4'(i);
            miss = {circuit_f2(m, v) != F2_REF[i], circuit_f1(m, v) != F1_REF[i]};
            if (miss != 2'b00) begin
                e.err = e.err + int'(miss[0]) + int'(miss[1]);
                if (!found) begin
                    e.idx = v;
                    e.fn  = miss;
                    found = 1;
                end
            end
        end
        e.pass   = (e.err == 0);
        e.edge_n = 16 * (settle + 1);
        return e;
    endfunction

    assign f1   = circuit_f1(mode, vec);
    assign f2   = circuit_f2(mode, vec);
    assign f1_0 = golden_f1(vec0);
    assign f2_0 = golden_f2(vec0);

    minterm_sweep_ctrl #(.SETTLE(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .vec_o(vec),
        .f1_i(f1), .f2_i(f2), .busy(busy), .done(done), .result_valid(result_valid),
        .pass(pass), .err_cnt(err_cnt), .fail_idx(fail_idx), .fail_fn(fail_fn)
    );

    minterm_sweep_ctrl #(.SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(1'b0), .vec_o(vec0),
        .f1_i(f1_0), .f2_i(f2_0), .busy(busy0), .done(done0), .result_valid(result_valid0),
        .pass(pass0), .err_cnt(err_cnt0), .fail_idx(fail_idx0), .fail_fn(fail_fn0)
    );

    // Runs one SETTLE=2 sweep, optionally pulsing start again while busy.
    task automatic run_sweep(input logic [1:0] m, input bit mid_start, input string tag);
        exp_t e;
        int   n;
        bit   seen;
        mode = m;
        sb.push_back(model(m, 2));
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        seen = 0;
        for (n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (mid_start && n == 10) start = 1'b1;
            if (mid_start && n == 11) start = 1'b0;
            if (done) begin
                seen = 1;
                break;
            end
        end
        e = sb.pop_front();
        checks++;
        if (seen && n == e.edge_n) passed++;
        else $display("[TB] FAIL %s done_edge: got %0d (seen=%0d) expected %0d", tag, n, seen, e.edge_n);
        checks++;
        if (err_cnt === 6'(e.err)) passed++;
        else $display("[TB] FAIL %s err_cnt: got %0d expected %0d", tag, err_cnt, e.err);
        checks++;
        if (fail_idx === e.idx) passed++;
        else $display("[TB] FAIL %s fail_idx: got %0d expected %0d", tag, fail_idx, e.idx);
        checks++;
        if (fail_fn === e.fn) passed++;
        else $display("[TB] FAIL %s fail_fn: got %b expected %b", tag, fail_fn, e.fn);
        @(posedge clk);
        #1;
        checks++;
        if (result_valid === 1'b1 && busy === 1'b0 && done === 1'b0) passed++;
        else $display("[TB] FAIL %s after_done: got rv=%b busy=%b done=%b expected rv=1 busy=0 done=0",
                      tag, result_valid, busy, done);
        checks++;
        if (pass === e.pass) passed++;
        else $display("[TB] FAIL %s pass: got %b expected %b", tag, pass, e.pass);
        checks++;
        if (vec === 4'd15) passed++;
        else $display("[TB] FAIL %s vec_hold: got %0d expected 15", tag, vec);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        start0 = 1'b0;
        mode   = 2'd0;
        #12;
        checks++;
        if ({vec, busy, done, result_valid, pass, err_cnt, fail_idx, fail_fn} === 20'd0) passed++;
        else $display("[TB] FAIL reset_outputs: got vec=%0d busy=%b done=%b rv=%b pass=%b err=%0d idx=%0d fn=%b expected all 0",
                      vec, busy, done, result_valid, pass, err_cnt, fail_idx, fail_fn);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_golden();
        run_sweep(2'd0, 0, "golden");
    endtask

    task automatic test_f1_stuck();
        run_sweep(2'd1, 0, "f1_stuck0");
    endtask

    task automatic test_both_stuck();
        run_sweep(2'd2, 0, "f1_0_f2_1");
    endtask

    task automatic test_abort();
        bit reached;
        bit saw_done;
        mode = 2'd0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        reached = 0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            #1;
            if (vec == 4'd7) begin
                reached = 1;
                break;
            end
        end
        checks++;
        if (reached) passed++;
        else $display("[TB] FAIL abort_reach_vec7: got vec=%0d expected 7", vec);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        checks++;
        if (busy === 1'b0 && done === 1'b0 && result_valid === 1'b0) passed++;
        else $display("[TB] FAIL abort_idle: got busy=%b done=%b rv=%b expected 0 0 0", busy, done, result_valid);
        checks++;
        if (vec === 4'd7 && err_cnt === 6'd0) passed++;
        else $display("[TB] FAIL abort_partial: got vec=%0d err=%0d expected 7 0", vec, err_cnt);
        saw_done = 0;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk);
            #1;
            if (done || busy) saw_done = 1;
        end
        checks++;
        if (!saw_done) passed++;
        else $display("[TB] FAIL abort_no_done: got activity=1 expected 0");
        run_sweep(2'd0, 0, "after_abort");
    endtask

    task automatic test_abort_start_idle();
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (busy === 1'b0 && result_valid === 1'b1) passed++;
        else $display("[TB] FAIL abort_start_idle: got busy=%b rv=%b expected 0 1", busy, result_valid);
    endtask

    task automatic test_async_reset();
        mode = 2'd1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({vec, busy, done, result_valid, pass, err_cnt, fail_idx, fail_fn} === 20'd0) passed++;
        else $display("[TB] FAIL async_reset: got vec=%0d busy=%b err=%0d idx=%0d fn=%b expected all 0",
                      vec, busy, err_cnt, fail_idx, fail_fn);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_sweep(2'd0, 1, "start_while_busy");
    endtask

    task automatic test_back_to_back();
        run_sweep(2'd1, 0, "b2b_first");
        run_sweep(2'd0, 0, "b2b_second");
    endtask

    task automatic test_settle_zero();
        int bad;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        bad = 0;
        if (vec0 !== 4'd0 || busy0 !== 1'b1) bad++;
        for (int k = 1; k < 16; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (vec0 === 4'(k) && done0 === 1'b0) passed++;
            else $display("[TB] FAIL settle0_vec: got %0d done=%b expected %0d done=0", vec0, done0, k);
        end
        checks++;
        if (bad == 0) passed++;
        else $display("[TB] FAIL settle0_first: got vec=%0d busy=%b expected 0 1", vec0, busy0);
        @(posedge clk);
        #1;
        checks++;
        if (done0 === 1'b1 && err_cnt0 === 6'd0) passed++;
        else $display("[TB] FAIL settle0_done_edge16: got done=%b err=%0d expected 1 0", done0, err_cnt0);
        @(posedge clk);
        #1;
        checks++;
        if (pass0 === 1'b1 && result_valid0 === 1'b1 && busy0 === 1'b0) passed++;
        else $display("[TB] FAIL settle0_result: got pass=%b rv=%b busy=%b expected 1 1 0",
                      pass0, result_valid0, busy0);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_golden();
        test_f1_stuck();
        test_both_stuck();
        test_abort();
        test_abort_start_idle();
        test_async_reset();
        test_back_to_back();
        test_settle_zero();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
